// File: rtl/core_pkg.sv
// Shared core defaults and types for the register file and its read ports.
// Types are sized from the default widths; parametrised blocks size their own buses.
package core_pkg;

    localparam int XLEN     = 32;
    localparam int NREG     = 32;
    localparam int AW       = $clog2(NREG);
    localparam int REG_ZERO = 0;

    typedef logic [AW-1:0]   reg_idx_t;
    typedef logic [XLEN-1:0] xword_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: r0 forcing, write-to-read bypass and busy masking.
// Zero latency; the hazard is masked when the completing write is forwarded.
module regfile_read_port
    import core_pkg::*;
#(
    parameter int XLEN   = core_pkg::XLEN,
    parameter int AW     = core_pkg::AW,
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] arr_data,
    input  logic            busy_bit,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_busy
);

    logic w_zero;
    logic w_hit;

    assign w_zero = (rd_addr == AW'(REG_ZERO));
    assign w_hit  = (BYPASS != 0) && wr_en && (wr_addr == rd_addr);

    always_comb begin
        rd_data = arr_data;
        rd_busy = busy_bit;
        if (w_zero) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end else if (w_hit) begin
            rd_data = wr_data;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with NUM_READ async read ports, one sync write port and a pending-write scoreboard.
// Reads are zero latency; writes and busy updates take effect at the next rising edge.
module regfile_scoreboard
    import core_pkg::*;
#(
    parameter int  XLEN     = core_pkg::XLEN,
    parameter int  NREG     = core_pkg::NREG,
    parameter int  NUM_READ = 2,
    parameter int  BYPASS   = 1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_READ*AW-1:0]   rd_addr,
    output logic [NUM_READ*XLEN-1:0] rd_data,
    output logic [NUM_READ-1:0]      rd_busy,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [XLEN-1:0]          wr_data,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr,
    output logic                     any_busy
);

    logic [XLEN-1:0] r_mem [NREG];
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_busy_nxt;

    // Set is applied after clear so a new producer supersedes the completing one.
    assign w_set      = iss_en ? (NREG'(1) << iss_addr) : '0;
    assign w_clr      = wr_en  ? (NREG'(1) << wr_addr)  : '0;
    assign w_busy_nxt = ((r_busy & ~w_clr) | w_set) & ~NREG'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (wr_en && (wr_addr != AW'(REG_ZERO))) begin
                r_mem[wr_addr] <= wr_data;
            end
            r_busy <= w_busy_nxt;
        end
    end

    assign any_busy = |r_busy;

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [AW-1:0] w_addr;

        assign w_addr = rd_addr[k*AW +: AW];

        regfile_read_port #(
            .XLEN   (XLEN),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_port (
            .rd_addr  (w_addr),
            .arr_data (r_mem[w_addr]),
            .busy_bit (r_busy[w_addr]),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rd_data  (rd_data[k*XLEN +: XLEN]),
            .rd_busy  (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: a 4-port bypassing instance and a 2-port non-bypassing instance share write/issue inputs.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;

    logic [19:0]  rd_addr_a;
    logic [127:0] rd_data_a;
    logic [3:0]   rd_busy_a;
    logic         any_busy_a;

    logic [9:0]   rd_addr_b;
    logic [63:0]  rd_data_b;
    logic [1:0]   rd_busy_b;
    logic         any_busy_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.XLEN(32), .NREG(32), .NUM_READ(4), .BYPASS(1)) u_dut_a (
        .clk(clk), .reset(reset), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .any_busy(any_busy_a)
    );

    regfile_scoreboard #(.XLEN(32), .NREG(32), .NUM_READ(2), .BYPASS(0)) u_dut_b (
        .clk(clk), .reset(reset), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .any_busy(any_busy_b)
    );

    // Advance one edge and return 1 time unit after it; checks then run #1 after inputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        rd_addr_a = {5'd0, 5'd0, 5'd0, 5'd5};
        rd_addr_b = {5'd0, 5'd5};
        tick(); tick();
        reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rd_data_a[k*32 +: 32] !== 32'h0 || rd_busy_a[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_read_a port=%0d data=%h busy=%b exp data=0 busy=0",
                         k, rd_data_a[k*32 +: 32], rd_busy_a[k]);
            end
        end
        checks++;
        if (rd_data_b !== 64'h0 || rd_busy_b !== 2'b00 || any_busy_a !== 1'b0 || any_busy_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_state data_b=%h busy_b=%b any_a=%b any_b=%b exp all 0",
                     rd_data_b, rd_busy_b, any_busy_a, any_busy_b);
        end
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF;
        rd_addr_a[4:0] = 5'd0;
        #1;
        checks++;
        if (rd_data_a[31:0] !== 32'h0 || rd_busy_a[0] !== 1'b0) begin
            failures++;
            $display("FAIL r0_bypass data=%h busy=%b exp 0 0", rd_data_a[31:0], rd_busy_a[0]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_data_a[31:0] !== 32'h0 || any_busy_a !== 1'b0) begin
            failures++;
            $display("FAIL r0_write data=%h any=%b exp 0 0", rd_data_a[31:0], any_busy_a);
        end
    endtask

    task automatic test_write_bypass();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
        rd_addr_a[4:0] = 5'd7;
        rd_addr_b[4:0] = 5'd7;
        #1;
        checks++;
        if (rd_data_a[31:0] !== 32'h12345678) begin
            failures++;
            $display("FAIL bypass_on data=%h exp 12345678", rd_data_a[31:0]);
        end
        checks++;
        if (rd_data_b[31:0] !== 32'h0) begin
            failures++;
            $display("FAIL bypass_off data=%h exp 00000000", rd_data_b[31:0]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_data_a[31:0] !== 32'h12345678 || rd_data_b[31:0] !== 32'h12345678
            || rd_busy_a[0] !== 1'b0 || any_busy_a !== 1'b0) begin
            failures++;
            $display("FAIL write_r7 a=%h b=%h busy=%b any=%b exp 12345678 12345678 0 0",
                     rd_data_a[31:0], rd_data_b[31:0], rd_busy_a[0], any_busy_a);
        end
    endtask

    task automatic test_hazard();
        iss_en = 1'b1; iss_addr = 5'd3;
        rd_addr_a[4:0] = 5'd3;
        rd_addr_b[4:0] = 5'd3;
        tick();
        idle();
        #1;
        checks++;
        if (rd_busy_a[0] !== 1'b1 || rd_busy_b[0] !== 1'b1 || any_busy_a !== 1'b1 || any_busy_b !== 1'b1) begin
            failures++;
            $display("FAIL issue_busy a=%b b=%b any_a=%b any_b=%b exp 1 1 1 1",
                     rd_busy_a[0], rd_busy_b[0], any_busy_a, any_busy_b);
        end
        tick(); tick();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5;
        #1;
        checks++;
        if (rd_data_a[31:0] !== 32'hA5 || rd_busy_a[0] !== 1'b0 || any_busy_a !== 1'b1) begin
            failures++;
            $display("FAIL complete_bypass data=%h busy=%b any=%b exp 000000a5 0 1",
                     rd_data_a[31:0], rd_busy_a[0], any_busy_a);
        end
        checks++;
        if (rd_data_b[31:0] !== 32'h0 || rd_busy_b[0] !== 1'b1) begin
            failures++;
            $display("FAIL complete_nobypass data=%h busy=%b exp 00000000 1",
                     rd_data_b[31:0], rd_busy_b[0]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_busy_a[0] !== 1'b0 || rd_busy_b[0] !== 1'b0 || any_busy_a !== 1'b0
            || any_busy_b !== 1'b0 || rd_data_b[31:0] !== 32'hA5) begin
            failures++;
            $display("FAIL after_complete busy_a=%b busy_b=%b any_a=%b any_b=%b data_b=%h exp 0 0 0 0 a5",
                     rd_busy_a[0], rd_busy_b[0], any_busy_a, any_busy_b, rd_data_b[31:0]);
        end
    endtask

    task automatic test_set_wins();
        iss_en = 1'b1; iss_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
        rd_addr_a[4:0] = 5'd9;
        rd_addr_b[4:0] = 5'd9;
        tick();
        idle();
        #1;
        checks++;
        if (rd_data_a[31:0] !== 32'h55 || rd_busy_a[0] !== 1'b1 || rd_busy_b[0] !== 1'b1 || any_busy_a !== 1'b1) begin
            failures++;
            $display("FAIL set_wins data=%h busy_a=%b busy_b=%b any=%b exp 00000055 1 1 1",
                     rd_data_a[31:0], rd_busy_a[0], rd_busy_b[0], any_busy_a);
        end
    endtask

    task automatic test_reset_midop();
        for (int r = 1; r < 32; r++) begin
            wr_en = 1'b1; wr_addr = 5'(r); wr_data = 32'(r);
            tick();
        end
        idle();
        rd_addr_a = {5'd31, 5'd17, 5'd4, 5'd1};
        #1;
        checks++;
        if (rd_data_a !== {32'd31, 32'd17, 32'd4, 32'd1}) begin
            failures++;
            $display("FAIL fill data=%h exp 0000001f000000110000000400000001", rd_data_a);
        end
        reset = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hFF;
        iss_en = 1'b1; iss_addr = 5'd5;
        tick();
        reset = 1'b0;
        idle();
        for (int r = 0; r < 32; r += 4) begin
            rd_addr_a = {5'(r + 3), 5'(r + 2), 5'(r + 1), 5'(r)};
            #1;
            checks++;
            if (rd_data_a !== 128'h0 || rd_busy_a !== 4'h0) begin
                failures++;
                $display("FAIL reset_clear base=%0d data=%h busy=%b exp 0 0", r, rd_data_a, rd_busy_a);
            end
        end
        checks++;
        if (any_busy_a !== 1'b0 || any_busy_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_any any_a=%b any_b=%b exp 0 0", any_busy_a, any_busy_b);
        end
    endtask

    task automatic test_multi_port();
        iss_en = 1'b1; iss_addr = 5'd12;
        tick();
        idle();
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hC0FFEE;
        rd_addr_a = {4{5'd12}};
        rd_addr_b = {2{5'd12}};
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rd_data_a[k*32 +: 32] !== 32'hC0FFEE || rd_busy_a[k] !== 1'b0) begin
                failures++;
                $display("FAIL multi_port port=%0d data=%h busy=%b exp 00c0ffee 0",
                         k, rd_data_a[k*32 +: 32], rd_busy_a[k]);
            end
        end
        checks++;
        if (rd_data_b !== 64'h0 || rd_busy_b !== 2'b11) begin
            failures++;
            $display("FAIL multi_port_nobypass data=%h busy=%b exp 0 11", rd_data_b, rd_busy_b);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_data_b !== {2{32'hC0FFEE}} || rd_busy_b !== 2'b00 || any_busy_a !== 1'b0) begin
            failures++;
            $display("FAIL multi_port_after data=%h busy=%b any=%b exp 00c0ffee00c0ffee 00 0",
                     rd_data_b, rd_busy_b, any_busy_a);
        end
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_hazard();
        test_set_wins();
        test_reset_midop();
        test_multi_port();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
